bin_to_bcd_conversion: RTL and testbench
========================================

Name: bin_to_bcd_conversion

Overview:
Sequential binary-to-BCD converter using iterative shift-and-add-3 (double-dabble).
It takes the binary result of the calculator datapath and produces packed BCD digits for the binary_to_7segment displays.
It is the return path for bcd_to_bin_conversion: that block feeds operands in; this block feeds results out.
It sits between the arithmetic result registers and the display nibble register of the top-level state machine.

Parameters:
WIDTH, 9, bit width of the binary input; sized for 9-bit operand/result paths.
DIGITS, 3, number of BCD output digits; MAX = 10^DIGITS - 1.

Ports:
i_Clk  input  1  system clock; all logic is on its rising edge.
i_Rst_L  input  1  synchronous active-low reset.
i_Bin  input  WIDTH  binary value; sampled only in the cycle i_Start is accepted.
i_Start  input  1  one-cycle request pulse.
o_BCD  output  4*DIGITS  packed BCD; digit 0 is in [3:0], most significant digit on top.
o_DV  output  1  one-cycle pulse; o_BCD is valid and new in that cycle.
o_Busy  output  1  conversion in progress.
o_Overflow  output  1  registered flag; last accepted i_Bin was greater than MAX.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is synchronous and active-low on i_Rst_L, and takes priority over everything else.
- Reset values: o_BCD=0, o_DV=0, o_Busy=0, o_Overflow=0, state=IDLE, shift counter=0, internal scratch=0.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - When i_Start=1 (cycle N): latch i_Bin into the shift register, clear the BCD scratch to 0, load counter=WIDTH, go to CONVERT.
  - Also compare i_Bin against MAX; store the result in an internal overflow bit.
- CONVERT (cycles N+1 .. N+WIDTH), one iteration per cycle:
  - Every scratch digit >= 5 gets +3.
  - Then shift {scratch, shift reg} left by 1.
  - Decrement the counter; when it reaches 0, go to DONE.
  - Scratch width is the minimum needed for WIDTH bits. Only the low DIGITS digits are exported.
- DONE (cycle N+WIDTH+1):
  - o_DV=1 for exactly this cycle.
  - o_BCD is updated in the same cycle and holds until the next DONE or reset.
  - o_Overflow is updated with o_DV and holds until the next DONE or reset.
  - Return to IDLE.
- Latency: i_Start to o_DV is WIDTH+1 cycles (10 at default). Throughput is one conversion per WIDTH+2 cycles.
- o_Busy: 1 from cycle N+1 through the DONE cycle inclusive; 0 in IDLE.
- i_Start while o_Busy=1: ignored, with no queueing. i_Bin changes during conversion have no effect.
- i_Start in the same cycle the block returns to IDLE (the cycle after DONE): accepted normally.
- Overflow (i_Bin > MAX): o_BCD = all digits 4'hF (blank code) and o_Overflow=1. Latency is unchanged.
- Reset low mid-conversion: immediate return to IDLE with reset values. No o_DV is produced.
- i_Bin=0: o_BCD=0, following the normal WIDTH-iteration path (no shortcut).

Optional Feature:
Macro BIN_TO_BCD_BLANK_EN.
- Defined: leading-zero blanking. Every zero digit above the most significant non-zero digit is output as 4'hF (blank on binary_to_7segment). Digit 0 is never blanked, so value 0 shows as a single "0". Blanking is applied in the DONE cycle; latency is unchanged.
- Undefined: all digits are output as plain BCD, including leading zeros.
- Overflow output is all 4'hF in both builds.

Decomposition:
- Shared package calc_pkg holds:
  - the state encodings (IDLE/CONVERT/DONE);
  - the BCD_BLANK = 4'hF constant, which the top-level display blanking also uses;
  - ADD3_THRESHOLD = 5;
  - a function computing MAX from DIGITS.
- One combinational sub-module, bcd_digit_adjust (4-bit in, 4-bit out: +3 if >= 5), instantiated once per scratch digit via generate.

Test Plan:
- Conversion of 198: i_Bin=198, i_Start pulse at cycle 0 -> o_Busy=1 over cycles 1..10, o_DV=1 only at cycle 10, o_BCD=12'h198, o_Overflow=0.
- Zero and maximum: i_Bin=0 -> o_BCD=12'h000 without the macro, 12'hFF0 with BIN_TO_BCD_BLANK_EN. i_Bin=511 -> 12'h511 in both builds.
- Blanking of a single digit: i_Bin=7 with BIN_TO_BCD_BLANK_EN -> 12'hFF7; without the macro -> 12'h007.
- Start while busy: second i_Start with i_Bin=42 at cycle 4 of a conversion of 99 -> exactly one o_DV, o_BCD=12'h099. A new i_Start the cycle after DONE converts 42 -> 12'h042.
- Reset mid-conversion: i_Rst_L=0 at cycle 5 -> next cycle o_Busy=0, o_BCD=0, and no o_DV within 20 cycles.
- Overflow build (DIGITS=2, WIDTH=9): i_Bin=100 -> o_DV at cycle 10, o_BCD=8'hFF, o_Overflow=1. Then i_Bin=99 -> 8'h99, o_Overflow=0.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types, constants and helper functions
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } conv_state_t;

    // Display code that binary_to_7segment renders as an unlit digit
    localparam logic [3:0] BCD_BLANK      = 4'hF;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Largest value representable in the given number of decimal digits
    function automatic int bcd_max(input int digits);
        int m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

    // Decimal digits needed to hold any unsigned value of the given bit width
    function automatic int bcd_digits_for_width(input int width);
        longint v;
        int     n;
        v = (64'sd1 <<< width) - 64'sd1;
        n = 0;
        do begin
            n = n + 1;
            v = v / 10;
        end while (v > 0);
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adjust
    import calc_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Digits of 5 or more would overflow past 9 after the shift, so pre-add 3
    always_comb begin
        digit_out = (digit_in >= ADD3_THRESHOLD) ? digit_in + 4'd3 : digit_in;
    end

endmodule

// File: rtl/bin_to_bcd_conversion.sv
// rtl/bin_to_bcd_conversion.sv - iterative binary to packed BCD converter, optional BIN_TO_BCD_BLANK_EN leading-zero blanking
module bin_to_bcd_conversion
    import calc_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [WIDTH-1:0]      i_Bin,
    input  logic                  i_Start,
    output logic [4*DIGITS-1:0]   o_BCD,
    output logic                  o_DV,
    output logic                  o_Busy,
    output logic                  o_Overflow
);

    localparam logic [31:0] MAX_VAL    = 32'(bcd_max(DIGITS));
    localparam int          NEED_DIGITS = bcd_digits_for_width(WIDTH);
    // Scratch must also cover every exported digit when DIGITS exceeds what WIDTH needs
    localparam int          SCR_DIGITS = (NEED_DIGITS > DIGITS) ? NEED_DIGITS : DIGITS;
    localparam int          SCR_W      = 4 * SCR_DIGITS;
    localparam int          CNT_W      = $clog2(WIDTH + 1);

    conv_state_t                state_q;
    conv_state_t                state_next;
    logic [WIDTH-1:0]           shift_q;
    logic [SCR_W-1:0]           scratch_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       ovf_q;

    logic [SCR_W-1:0]           adjusted;
    logic [SCR_W+WIDTH-1:0]     shifted;
    logic [SCR_W-1:0]           scratch_next;
    logic [WIDTH-1:0]           shift_next;
    logic [4*DIGITS-1:0]        bcd_fmt;
    logic                       over_max;
    logic                       last_iter;

`ifdef BIN_TO_BCD_BLANK_EN
    logic                       leading;
`endif

    genvar g;
    generate
        for (g = 0; g < SCR_DIGITS; g++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch_q[4*g +: 4]),
                .digit_out (adjusted[4*g +: 4])
            );
        end
    endgenerate

    // One double-dabble step: corrected scratch and binary shifted left together
    always_comb begin
        shifted      = {adjusted, shift_q} << 1;
        scratch_next = shifted[SCR_W+WIDTH-1:WIDTH];
        shift_next   = shifted[WIDTH-1:0];
        over_max     = (32'(i_Bin) > MAX_VAL);
        last_iter    = (cnt_q == CNT_W'(1));
    end

    // Format the final scratch for display: blank on overflow, optional leading-zero blanking
    always_comb begin
        bcd_fmt = scratch_next[4*DIGITS-1:0];
`ifdef BIN_TO_BCD_BLANK_EN
        leading = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
            if (leading && (bcd_fmt[4*d +: 4] == 4'd0)) begin
                bcd_fmt[4*d +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
`endif
        if (ovf_q) begin
            bcd_fmt = {DIGITS{BCD_BLANK}};
        end
    end

    // State register
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic; starts while busy are simply not looked at
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (i_Start)   state_next = CONVERT;
            CONVERT: if (last_iter) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        o_Busy = (state_q != IDLE);
        o_DV   = (state_q == DONE);
    end

    // Datapath: load on accept, iterate in CONVERT, publish result on the last step
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            o_BCD      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Start) begin
                        shift_q   <= i_Bin;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(WIDTH);
                        ovf_q     <= over_max;
                    end
                end
                CONVERT: begin
                    shift_q   <= shift_next;
                    scratch_q <= scratch_next;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        o_BCD      <= bcd_fmt;
                        o_Overflow <= ovf_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_conversion.sv
// tb/tb_bin_to_bcd_conversion.sv - directed vector bench for bin_to_bcd_conversion
module tb_bin_to_bcd_conversion;

    typedef struct {
        logic [8:0]  bin;
        logic [11:0] plain3;
        logic [11:0] blank3;
        logic [7:0]  plain2;
        logic [7:0]  blank2;
        logic        ovf2;
    } vec_t;

    logic        i_Clk   = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic        i_Start = 1'b0;
    logic [8:0]  i_Bin   = '0;

    logic [11:0] bcd3;
    logic        dv3, busy3, ovf3;
    logic [7:0]  bcd2;
    logic        dv2, busy2, ovf2;

    int total = 0;
    int bad   = 0;
    int dv_count;

    vec_t vecs [10];

    always #5 i_Clk = ~i_Clk;

    bin_to_bcd_conversion #(.WIDTH(9), .DIGITS(3)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Bin      (i_Bin),
        .i_Start    (i_Start),
        .o_BCD      (bcd3),
        .o_DV       (dv3),
        .o_Busy     (busy3),
        .o_Overflow (ovf3)
    );

    bin_to_bcd_conversion #(.WIDTH(9), .DIGITS(2)) dut2 (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Bin      (i_Bin),
        .i_Start    (i_Start),
        .o_BCD      (bcd2),
        .o_DV       (dv2),
        .o_Busy     (busy2),
        .o_Overflow (ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_Clk);
        #1;
    endtask

    function automatic logic [11:0] exp3(input vec_t v);
`ifdef BIN_TO_BCD_BLANK_EN
        return v.blank3;
`else
        return v.plain3;
`endif
    endfunction

    function automatic logic [7:0] exp2(input vec_t v);
`ifdef BIN_TO_BCD_BLANK_EN
        return v.blank2;
`else
        return v.plain2;
`endif
    endfunction

    // Start in the current cycle (cycle 0), check cycles 1..10, return in cycle 11
    task automatic run_conv(input vec_t v);
        string tag;
        tag = $sformatf("bin%0d", v.bin);
        i_Bin   = v.bin;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check({tag, " busy"}, 32'(busy3), 32'(1));
            check({tag, " dv"}, 32'(dv3), 32'(k == 10));
            if (k == 10) begin
                check({tag, " bcd3"}, 32'(bcd3), 32'(exp3(v)));
                check({tag, " ovf3"}, 32'(ovf3), 32'(0));
                check({tag, " dv2"}, 32'(dv2), 32'(1));
                check({tag, " bcd2"}, 32'(bcd2), 32'(exp2(v)));
                check({tag, " ovf2"}, 32'(ovf2), 32'(v.ovf2));
            end else begin
                tick;
            end
        end
        tick;
        check({tag, " idle busy"}, 32'(busy3), 32'(0));
        check({tag, " idle dv"}, 32'(dv3), 32'(0));
        check({tag, " hold bcd3"}, 32'(bcd3), 32'(exp3(v)));
    endtask

    initial begin
        vecs[0] = '{9'd198, 12'h198, 12'h198, 8'h99, 8'hFF, 1'b1};
        vecs[0].plain2 = 8'hFF;
        vecs[1] = '{9'd0,   12'h000, 12'hFF0, 8'h00, 8'hF0, 1'b0};
        vecs[2] = '{9'd511, 12'h511, 12'h511, 8'hFF, 8'hFF, 1'b1};
        vecs[3] = '{9'd7,   12'h007, 12'hFF7, 8'h07, 8'hF7, 1'b0};
        vecs[4] = '{9'd100, 12'h100, 12'h100, 8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{9'd99,  12'h099, 12'hF99, 8'h99, 8'h99, 1'b0};
        vecs[6] = '{9'd10,  12'h010, 12'hF10, 8'h10, 8'h10, 1'b0};
        vecs[7] = '{9'd255, 12'h255, 12'h255, 8'hFF, 8'hFF, 1'b1};
        vecs[8] = '{9'd1,   12'h001, 12'hFF1, 8'h01, 8'hF1, 1'b0};
        vecs[9] = '{9'd42,  12'h042, 12'hF42, 8'h42, 8'h42, 1'b0};

        // Reset state
        i_Rst_L = 1'b0;
        tick;
        tick;
        check("reset bcd", 32'(bcd3), 32'(0));
        check("reset dv", 32'(dv3), 32'(0));
        check("reset busy", 32'(busy3), 32'(0));
        check("reset ovf", 32'(ovf3), 32'(0));
        i_Rst_L = 1'b1;
        tick;

        // Table-driven conversions, back to back (each start lands in the cycle after DONE)
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i]);
        end

        // Start while busy is dropped; i_Bin changes have no effect
        dv_count = 0;
        i_Bin    = 9'd99;
        i_Start  = 1'b1;
        tick;
        i_Start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) begin
                i_Bin   = 9'd42;
                i_Start = 1'b1;
            end else begin
                i_Start = 1'b0;
            end
            dv_count += int'(dv3);
            if (k == 10) begin
                check("busy-start bcd", 32'(bcd3), 32'(exp3(vecs[5])));
                check("busy-start dv at 10", 32'(dv3), 32'(1));
            end else begin
                tick;
            end
        end
        i_Start = 1'b0;
        tick;
        dv_count += int'(dv3);
        check("busy-start dv count", 32'(dv_count), 32'(1));
        check("busy-start idle", 32'(busy3), 32'(0));
        run_conv(vecs[9]);

        // Reset in the middle of a conversion
        i_Bin   = 9'd198;
        i_Start = 1'b1;
        tick;
        i_Start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick;
        end
        check("pre-reset busy", 32'(busy3), 32'(1));
        i_Rst_L = 1'b0;
        tick;
        check("mid-reset busy", 32'(busy3), 32'(0));
        check("mid-reset bcd", 32'(bcd3), 32'(0));
        check("mid-reset dv", 32'(dv3), 32'(0));
        i_Rst_L  = 1'b1;
        dv_count = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            dv_count += int'(dv3);
        end
        check("mid-reset no dv", 32'(dv_count), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
